adsr_scheduler: RTL and testbench

//  Time-multiplexing controller for the 32-voice RAM-based ADSR engine.
//  - Once per sample tick: sweeps every voice, one slot per voice.
//  - Per slot: drives the engine's ena/sel and presents that voice's gate and A/D/S/R/expo_R.
//  - Captures the updated 18-bit envelope into a per-voice stream.

---
 rtl/adsr_sched_pkg.sv | 39 +++
 rtl/adsr_param_ram.sv | 39 +++
 rtl/adsr_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_adsr_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adsr_sched_pkg.sv
// Shared constants, state encoding and parameter-record layout for the
// ADSR voice scheduler.
package adsr_sched_pkg;

  localparam int NUM_VOICES = 32;
  localparam int SLOT_CLKS  = 4;
  localparam int VOICE_W    = 5;
  localparam int ENV_W      = 18;
  localparam int RATE_W     = 14;
  localparam int SUS_W      = 17;
  localparam int PHASE_W    = $clog2(SLOT_CLKS);

  localparam logic [PHASE_W-1:0] CAP_PHASE  = PHASE_W'(2);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(SLOT_CLKS - 1);
  localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(NUM_VOICES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    FLD_A    = 3'd0,
    FLD_D    = 3'd1,
    FLD_S    = 3'd2,
    FLD_R    = 3'd3,
    FLD_EXPO = 3'd4
  } cfg_field_t;

  // One voice's patch: 14+14+17+14+1 = 60 bits.
  typedef struct packed {
    logic [RATE_W-1:0] a;
    logic [RATE_W-1:0] d;
    logic [SUS_W-1:0]  s;
    logic [RATE_W-1:0] r;
    logic              expo_r;
  } param_t;

endpackage

// File: rtl/adsr_param_ram.sv
// Per-voice patch storage: NUM_VOICES x 60-bit distributed RAM with
// per-field write enables and asynchronous read. Contents survive reset.
module adsr_param_ram
  import adsr_sched_pkg::*;
(
  input  logic               clk,
  input  logic [VOICE_W-1:0] wr_voice,
  input  logic               we_a,
  input  logic               we_d,
  input  logic               we_s,
  input  logic               we_r,
  input  logic               we_expo,
  input  logic [SUS_W-1:0]   wr_data,
  input  logic [VOICE_W-1:0] rd_voice,
  output param_t             rd_data
);

  param_t mem_q [NUM_VOICES];
  param_t mem_d [NUM_VOICES];

  // Merge field writes into the addressed entry; only cfg_data is truncated.
  always_comb begin
    mem_d = mem_q;
    if (we_a)    mem_d[wr_voice].a      = wr_data[RATE_W-1:0];
    if (we_d)    mem_d[wr_voice].d      = wr_data[RATE_W-1:0];
    if (we_s)    mem_d[wr_voice].s      = wr_data[SUS_W-1:0];
    if (we_r)    mem_d[wr_voice].r      = wr_data[RATE_W-1:0];
    if (we_expo) mem_d[wr_voice].expo_r = wr_data[0];
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Read sees the pre-write contents on a same-edge collision.
  assign rd_data = mem_q[rd_voice];

endmodule

// File: rtl/adsr_scheduler.sv
// Time-multiplexing controller for the 32-voice RAM-based ADSR engine.
// Each tick sweeps all voices, one SLOT_CLKS-clock slot per voice, and
// captures the engine output of each voice into an (env_voice, env_out) stream.
// Optional feature macro: ADSR_SCHED_RETRIG_EN (gate retrigger via pend bits).
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | waiting for tick; held slot outputs keep last values
//  ST_SCAN | sweeping voices 0..NUM_VOICES-1, phase 0..SLOT_CLKS-1 each
module adsr_scheduler
  import adsr_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               gate_we,
  input  logic [VOICE_W-1:0] gate_voice,
  input  logic               gate_val,
  input  logic               retrig,
  input  logic               cfg_we,
  input  logic [VOICE_W-1:0] cfg_voice,
  input  logic [2:0]         cfg_field,
  input  logic [SUS_W-1:0]   cfg_data,
  output logic               adsr_ena,
  output logic [VOICE_W-1:0] adsr_sel,
  output logic               adsr_gate,
  output logic [RATE_W-1:0]  adsr_a,
  output logic [RATE_W-1:0]  adsr_d,
  output logic [SUS_W-1:0]   adsr_s,
  output logic [RATE_W-1:0]  adsr_r,
  output logic               adsr_expo_r,
  input  logic [ENV_W-1:0]   env_in,
  output logic               env_valid,
  output logic [VOICE_W-1:0] env_voice,
  output logic [ENV_W-1:0]   env_out,
  output logic               scan_done,
  output logic               overrun
);

  state_t                state_q,     state_d;
  logic [PHASE_W-1:0]    phase_q,     phase_d;
  logic [VOICE_W-1:0]    voice_q,     voice_d;
  logic [NUM_VOICES-1:0] gate_q,      gate_d;
  logic                  ena_q,       ena_d;
  logic [VOICE_W-1:0]    sel_q,       sel_d;
  logic                  gate_out_q,  gate_out_d;
  param_t                prm_q,       prm_d;
  logic                  env_valid_q, env_valid_d;
  logic [VOICE_W-1:0]    env_voice_q, env_voice_d;
  logic [ENV_W-1:0]      env_out_q,   env_out_d;
  logic                  scan_done_q, scan_done_d;
  logic                  overrun_q,   overrun_d;

`ifdef ADSR_SCHED_RETRIG_EN
  logic [NUM_VOICES-1:0] pend_q, pend_d;
`else
  logic unused_retrig;
  assign unused_retrig = retrig;
`endif

  logic               setup;
  logic [VOICE_W-1:0] slot_voice;
  param_t             rd_data;

  adsr_param_ram u_param_ram (
    .clk      (clk),
    .wr_voice (cfg_voice),
    .we_a     (cfg_we && (cfg_field == FLD_A)),
    .we_d     (cfg_we && (cfg_field == FLD_D)),
    .we_s     (cfg_we && (cfg_field == FLD_S)),
    .we_r     (cfg_we && (cfg_field == FLD_R)),
    .we_expo  (cfg_we && (cfg_field == FLD_EXPO)),
    .wr_data  (cfg_data),
    .rd_voice (slot_voice),
    .rd_data  (rd_data)
  );

  // Sweep FSM, slot counters, slot setup, capture and gate/pend bookkeeping.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    voice_d     = voice_q;
    gate_d      = gate_q;
    ena_d       = 1'b0;
    sel_d       = sel_q;
    gate_out_d  = gate_out_q;
    prm_d       = prm_q;
    env_valid_d = 1'b0;
    env_voice_d = env_voice_q;
    env_out_d   = env_out_q;
    scan_done_d = 1'b0;
    overrun_d   = overrun_q;
    setup       = 1'b0;
    slot_voice  = '0;
`ifdef ADSR_SCHED_RETRIG_EN
    pend_d      = pend_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d    = ST_SCAN;
          phase_d    = '0;
          voice_d    = '0;
          setup      = 1'b1;
          slot_voice = '0;
        end
      end
      ST_SCAN: begin
        // A tick here, even on the last clock, only flags overrun.
        if (tick) overrun_d = 1'b1;
        if (phase_q == CAP_PHASE) begin
          env_valid_d = 1'b1;
          env_voice_d = voice_q;
          env_out_d   = env_in;
          scan_done_d = (voice_q == LAST_VOICE);
        end
        if (phase_q == LAST_PHASE) begin
          phase_d = '0;
          if (voice_q == LAST_VOICE) begin
            state_d = ST_IDLE;
            voice_d = '0;
          end else begin
            voice_d    = voice_q + 1'b1;
            setup      = 1'b1;
            slot_voice = voice_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Slot outputs are loaded only here, so writes during a slot wait
    // until the voice's next service.
    if (setup) begin
      ena_d      = 1'b1;
      sel_d      = slot_voice;
      gate_out_d = gate_q[slot_voice];
      prm_d      = rd_data;
`ifdef ADSR_SCHED_RETRIG_EN
      // A pending retrigger forces one release sample before re-attack.
      gate_out_d         = gate_q[slot_voice] & ~pend_q[slot_voice];
      pend_d[slot_voice] = 1'b0;
`endif
    end

    if (gate_we) begin
      gate_d[gate_voice] = gate_val;
`ifdef ADSR_SCHED_RETRIG_EN
      if (gate_val && retrig) pend_d[gate_voice] = 1'b1;
      else if (!gate_val)     pend_d[gate_voice] = 1'b0;
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      voice_q     <= '0;
      gate_q      <= '0;
      ena_q       <= 1'b0;
      sel_q       <= '0;
      gate_out_q  <= 1'b0;
      prm_q       <= '0;
      env_valid_q <= 1'b0;
      env_voice_q <= '0;
      env_out_q   <= '0;
      scan_done_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef ADSR_SCHED_RETRIG_EN
      pend_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      voice_q     <= voice_d;
      gate_q      <= gate_d;
      ena_q       <= ena_d;
      sel_q       <= sel_d;
      gate_out_q  <= gate_out_d;
      prm_q       <= prm_d;
      env_valid_q <= env_valid_d;
      env_voice_q <= env_voice_d;
      env_out_q   <= env_out_d;
      scan_done_q <= scan_done_d;
      overrun_q   <= overrun_d;
`ifdef ADSR_SCHED_RETRIG_EN
      pend_q      <= pend_d;
`endif
    end
  end

  assign adsr_ena    = ena_q;
  assign adsr_sel    = sel_q;
  assign adsr_gate   = gate_out_q;
  assign adsr_a      = prm_q.a;
  assign adsr_d      = prm_q.d;
  assign adsr_s      = prm_q.s;
  assign adsr_r      = prm_q.r;
  assign adsr_expo_r = prm_q.expo_r;
  assign env_valid   = env_valid_q;
  assign env_voice   = env_voice_q;
  assign env_out     = env_out_q;
  assign scan_done   = scan_done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_adsr_scheduler.sv
// Directed bench for adsr_scheduler with a toy per-voice envelope engine:
// on ena, gated voices step +16, ungated voices step -4 (floor 0).
module tb_adsr_scheduler;

  logic        clk = 1'b0;
  logic        rst, tick, gate_we, gate_val, retrig, cfg_we;
  logic [4:0]  gate_voice, cfg_voice;
  logic [2:0]  cfg_field;
  logic [16:0] cfg_data;
  logic        adsr_ena, adsr_gate, adsr_expo_r, env_valid, scan_done, overrun;
  logic [4:0]  adsr_sel, env_voice;
  logic [13:0] adsr_a, adsr_d, adsr_r;
  logic [16:0] adsr_s;
  logic [17:0] env_in, env_out;

  int checks = 0;
  int errors = 0;

  int ena_cnt, ena_bad, val_cnt, val_bad, done_cnt, done_bad;
  logic        gate_at  [32];
  logic        gate_end [32];
  logic [13:0] a_at [32];
  logic [13:0] d_at [32];
  logic [16:0] s_at [32];
  logic [13:0] r_at [32];
  logic        expo_at [32];
  logic [17:0] env_at [32];

  logic [17:0] env_mem [32] = '{default: '0};

  always #10 clk = ~clk;

  adsr_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick),
    .gate_we(gate_we), .gate_voice(gate_voice), .gate_val(gate_val), .retrig(retrig),
    .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .adsr_ena(adsr_ena), .adsr_sel(adsr_sel), .adsr_gate(adsr_gate),
    .adsr_a(adsr_a), .adsr_d(adsr_d), .adsr_s(adsr_s), .adsr_r(adsr_r),
    .adsr_expo_r(adsr_expo_r), .env_in(env_in),
    .env_valid(env_valid), .env_voice(env_voice), .env_out(env_out),
    .scan_done(scan_done), .overrun(overrun)
  );

  // Toy engine: updated value visible from the clock after ena.
  always @(posedge clk) begin
    if (adsr_ena)
      env_mem[adsr_sel] <= adsr_gate ? env_mem[adsr_sel] + 18'd16 :
                           (env_mem[adsr_sel] >= 18'd4 ? env_mem[adsr_sel] - 18'd4 : 18'd0);
  end
  assign env_in = env_mem[adsr_sel];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cfg_wr(input logic [4:0] v, input logic [2:0] f, input logic [16:0] d);
    cfg_we = 1'b1; cfg_voice = v; cfg_field = f; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic gate_wr(input logic [4:0] v, input logic val, input logic rt);
    gate_we = 1'b1; gate_voice = v; gate_val = val; retrig = rt;
    step();
    gate_we = 1'b0; retrig = 1'b0;
  endtask

  // One full sweep; k indexes samples taken 1 time unit after each edge,
  // k=0 being just after the edge that samples tick.
  task automatic sweep(input int xtick_at, input int gw_at, input logic [4:0] gw_v, input logic gw_val);
    ena_cnt = 0; ena_bad = 0; val_cnt = 0; val_bad = 0; done_cnt = 0; done_bad = 0;
    for (int v = 0; v < 32; v++) env_at[v] = 18'h3FFFF;
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int k = 0; k < 130; k++) begin
      if (adsr_ena) begin
        if (k < 128 && k % 4 == 0 && adsr_sel == 5'(k / 4)) ena_cnt++;
        else ena_bad++;
        gate_at[adsr_sel] = adsr_gate;
        a_at[adsr_sel]    = adsr_a;
        d_at[adsr_sel]    = adsr_d;
        s_at[adsr_sel]    = adsr_s;
        r_at[adsr_sel]    = adsr_r;
        expo_at[adsr_sel] = adsr_expo_r;
      end
      if (k < 128 && k % 4 == 3) gate_end[k / 4] = adsr_gate;
      if (env_valid) begin
        if (k < 128 && k % 4 == 3 && env_voice == 5'(k / 4)) val_cnt++;
        else val_bad++;
        env_at[env_voice] = env_out;
      end
      if (scan_done) begin
        if (k == 127 && env_valid) done_cnt++;
        else done_bad++;
      end
      if (k == xtick_at) tick = 1'b1;
      if (k == gw_at) begin
        gate_we = 1'b1; gate_voice = gw_v; gate_val = gw_val;
      end
      step();
      tick = 1'b0;
      gate_we = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; gate_we = 1'b0; gate_val = 1'b0; retrig = 1'b0;
    gate_voice = '0; cfg_we = 1'b0; cfg_voice = '0; cfg_field = '0; cfg_data = '0;
    #1;
    repeat (3) step();

    // Reset state
    chk("rst_ena", 32'(adsr_ena), 0);
    chk("rst_sel", 32'(adsr_sel), 0);
    chk("rst_gate", 32'(adsr_gate), 0);
    chk("rst_a", 32'(adsr_a), 0);
    chk("rst_env_valid", 32'(env_valid), 0);
    chk("rst_env_out", 32'(env_out), 0);
    chk("rst_scan_done", 32'(scan_done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    step();

    // Patch bank: A=v, D=v+100, S=v+1000, R=v+200, expo=v[0]
    for (int v = 0; v < 32; v++) begin
      cfg_wr(5'(v), 3'd0, 17'(v));
      cfg_wr(5'(v), 3'd1, 17'(v + 100));
      cfg_wr(5'(v), 3'd2, 17'(v + 1000));
      cfg_wr(5'(v), 3'd3, 17'(v + 200));
      cfg_wr(5'(v), 3'd4, 17'(v % 2));
    end
    cfg_wr(5'd5, 3'd0, 17'h1FFFF);   // truncates to 3FFF
    gate_wr(5'd5, 1'b1, 1'b0);
    gate_wr(5'd7, 1'b1, 1'b0);
    gate_wr(5'd3, 1'b1, 1'b0);
    repeat (2) step();

    // Sweep 1: basic timing and parameter presentation
    sweep(-1, -1, 5'd0, 1'b0);
    chk("s1_ena_cnt", 32'(ena_cnt), 32);
    chk("s1_ena_bad", 32'(ena_bad), 0);
    chk("s1_valid_cnt", 32'(val_cnt), 32);
    chk("s1_valid_bad", 32'(val_bad), 0);
    chk("s1_done_cnt", 32'(done_cnt), 1);
    chk("s1_done_bad", 32'(done_bad), 0);
    chk("s1_gate_v5", 32'(gate_at[5]), 1);
    chk("s1_gate_v0", 32'(gate_at[0]), 0);
    chk("s1_a_v5", 32'(a_at[5]), 32'h3FFF);
    chk("s1_a_v9", 32'(a_at[9]), 9);
    chk("s1_expo_v9", 32'(expo_at[9]), 1);
    chk("s1_expo_v8", 32'(expo_at[8]), 0);
    chk("s1_env_v5", 32'(env_at[5]), 16);
    chk("s1_env_v0", 32'(env_at[0]), 0);
    chk("s1_overrun", 32'(overrun), 0);

    // Reserved field code must not disturb any field
    cfg_wr(5'd9, 3'd5, 17'h1FFFF);
    repeat (2) step();

    // Sweep 2: gate v7 cleared during its slot phase 1
    sweep(-1, 29, 5'd7, 1'b0);
    chk("s2_gate_v7_start", 32'(gate_at[7]), 1);
    chk("s2_gate_v7_held", 32'(gate_end[7]), 1);
    chk("s2_env_v5", 32'(env_at[5]), 32);
    chk("s2_env_v7", 32'(env_at[7]), 32);
    chk("s2_a_v9", 32'(a_at[9]), 9);
    chk("s2_d_v9", 32'(d_at[9]), 109);
    chk("s2_s_v9", 32'(s_at[9]), 1009);
    chk("s2_r_v9", 32'(r_at[9]), 209);
    repeat (2) step();

    // Sweep 3: v7 now released; extra tick 50 clks in
    sweep(50, -1, 5'd0, 1'b0);
    chk("s3_gate_v7", 32'(gate_at[7]), 0);
    chk("s3_env_v7", 32'(env_at[7]), 28);
    chk("s3_env_v5", 32'(env_at[5]), 48);
    chk("s3_ena_cnt", 32'(ena_cnt), 32);
    chk("s3_ena_bad", 32'(ena_bad), 0);
    chk("s3_done_cnt", 32'(done_cnt), 1);
    chk("s3_done_bad", 32'(done_bad), 0);
    chk("s3_overrun", 32'(overrun), 1);
    repeat (5) step();
    chk("s3_overrun_sticky", 32'(overrun), 1);

    // Sweep 4: reset at voice 10, phase 2
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (42) step();
    chk("s4_sel_before_rst", 32'(adsr_sel), 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s4_rst_ena", 32'(adsr_ena), 0);
    chk("s4_rst_sel", 32'(adsr_sel), 0);
    chk("s4_rst_gate", 32'(adsr_gate), 0);
    chk("s4_rst_prm", 32'({adsr_a, adsr_d} | 28'(adsr_s) | 28'(adsr_r) | 28'(adsr_expo_r)), 0);
    chk("s4_rst_env_valid", 32'(env_valid), 0);
    chk("s4_rst_env_out", 32'({env_voice, 9'd0} | 14'(env_out)), 0);
    chk("s4_rst_overrun", 32'(overrun), 0);
    step();
    chk("s4_no_valid_after", 32'(env_valid), 0);
    chk("s4_no_ena_after", 32'(adsr_ena), 0);
    gate_wr(5'd3, 1'b1, 1'b0);
    repeat (2) step();

    // Sweep 5: restart at voice 0; tick on final SCAN clock
    sweep(127, -1, 5'd0, 1'b0);
    chk("s5_ena_cnt", 32'(ena_cnt), 32);
    chk("s5_ena_bad", 32'(ena_bad), 0);
    chk("s5_gate_v5_cleared", 32'(gate_at[5]), 0);
    chk("s5_a_v5_kept", 32'(a_at[5]), 32'h3FFF);
    chk("s5_env_v3", 32'(env_at[3]), 80);
    chk("s5_env_v5", 32'(env_at[5]), 60);
    chk("s5_overrun_last", 32'(overrun), 1);

    // Retrigger of v3 while sustaining
    gate_wr(5'd3, 1'b1, 1'b1);
    repeat (2) step();
    sweep(-1, -1, 5'd0, 1'b0);
`ifdef ADSR_SCHED_RETRIG_EN
    chk("s6_gate_v3", 32'(gate_at[3]), 0);
    chk("s6_env_v3", 32'(env_at[3]), 76);
`else
    chk("s6_gate_v3", 32'(gate_at[3]), 1);
    chk("s6_env_v3", 32'(env_at[3]), 96);
`endif
    repeat (2) step();
    sweep(-1, -1, 5'd0, 1'b0);
    chk("s7_gate_v3", 32'(gate_at[3]), 1);
`ifdef ADSR_SCHED_RETRIG_EN
    chk("s7_env_v3", 32'(env_at[3]), 92);
`else
    chk("s7_env_v3", 32'(env_at[3]), 112);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
